// File: rtl/sfp_seq_ctrl.sv
// Sequencer for one row of acc/relu special-function units: per output index it
// clears the accumulators, streams K psums from psum memory, optionally applies relu, writes out.
module sfp_seq_ctrl #(
    parameter int unsigned K       = 9,
    parameter int unsigned O       = 16,
    parameter int unsigned addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               relu_en,
    output logic               busy,
    output logic               done,
    output logic               pmem_ren,
    output logic [addr_bw-1:0] pmem_addr,
    output logic               sfp_clr,
    output logic               sfp_acc,
    output logic               sfp_relu,
    output logic               omem_wen,
    output logic [addr_bw-1:0] omem_addr
);

    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned OW = (O > 1) ? $clog2(O) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RD,
        S_LAST,
        S_RELU,
        S_WR,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [KW-1:0]      k, k_n;
    logic [OW-1:0]      o, o_n;
    logic [addr_bw-1:0] rd_addr, rd_addr_n;
    logic               relu_lat, relu_lat_n;

    logic               busy_n, done_n, ren_n, clr_n, relu_n, wen_n;
    logic [addr_bw-1:0] paddr_n, oaddr_n;

    // Outputs are registered from the next state, so each output is asserted
    // during exactly the cycle in which the FSM occupies the matching state.
    always_comb begin
        state_n    = state;
        k_n        = k;
        o_n        = o;
        rd_addr_n  = rd_addr;
        relu_lat_n = relu_lat;
        paddr_n    = '0;
        oaddr_n    = '0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_CLR;
                    relu_lat_n = relu_en;
                    o_n        = '0;
                    rd_addr_n  = '0;
                end
            end
            S_CLR: begin
                k_n     = '0;
                state_n = S_RD;
            end
            S_RD: begin
                k_n = k + 1'b1;
                if (k == KW'(K - 1)) state_n = S_LAST;
            end
            S_LAST: state_n = S_RELU;
            S_RELU: state_n = S_WR;
            S_WR: begin
                if (o == OW'(O - 1)) begin
                    state_n = S_DONE;
                end else begin
                    o_n       = o + 1'b1;
                    rd_addr_n = addr_bw'(o_n);
                    state_n   = S_CLR;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // rd_addr holds the address of the next read; it steps by O per kernel position.
        if (state_n == S_RD) begin
            paddr_n   = rd_addr;
            rd_addr_n = rd_addr + addr_bw'(O);
        end
        if (state_n == S_WR) oaddr_n = addr_bw'(o_n);

        busy_n = (state_n == S_CLR) || (state_n == S_RD) || (state_n == S_LAST) ||
                 (state_n == S_RELU) || (state_n == S_WR);
        done_n = (state_n == S_DONE);
        ren_n  = (state_n == S_RD);
        clr_n  = (state_n == S_CLR);
        relu_n = (state_n == S_RELU) && relu_lat_n;
        wen_n  = (state_n == S_WR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            o         <= '0;
            rd_addr   <= '0;
            relu_lat  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pmem_ren  <= 1'b0;
            pmem_addr <= '0;
            sfp_clr   <= 1'b0;
            sfp_acc   <= 1'b0;
            sfp_relu  <= 1'b0;
            omem_wen  <= 1'b0;
            omem_addr <= '0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            o         <= o_n;
            rd_addr   <= rd_addr_n;
            relu_lat  <= relu_lat_n;
            busy      <= busy_n;
            done      <= done_n;
            pmem_ren  <= ren_n;
            pmem_addr <= paddr_n;
            sfp_clr   <= clr_n;
            sfp_acc   <= pmem_ren;
            sfp_relu  <= relu_n;
            omem_wen  <= wen_n;
            omem_addr <= oaddr_n;
        end
    end

endmodule
